// File: rtl/sdram_resp.sv
// rtl/sdram_resp.sv - SDRAM device responder: decodes controller commands, stores write bursts, returns read bursts after CAS latency
// Also flags protocol errors (sticky flag plus most-recent code) and counts AUTO REFRESH commands.
module sdram_resp #(
    parameter int MEM_AW = 10
) (
    input  logic        clk_100M,
    input  logic        locked_rst_n,
    input  logic [3:0]  sdram_cmd,
    input  logic [1:0]  sdram_bank_addr,
    input  logic [12:0] sdram_addr,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        mode_loaded,
    output logic        err_flag,
    output logic [2:0]  err_code,
    output logic [15:0] ref_cnt
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_RD_BURST} state_t;

    state_t             state_q, state_d;
    logic [1:0]         bank_q, bank_d;
    logic [12:0]        row_q, row_d;
    logic [8:0]         col_q, col_d;
    logic [8:0]         cnt_q, cnt_d;

    logic [3:0]         bank_open_q;
    logic [12:0]        open_row_q [4];
    logic               cl3_q;
    logic [2:0]         bl_code_q;
    logic               mode_loaded_q;
    logic               err_flag_q;
    logic [2:0]         err_code_q, err_code_d;
    logic [15:0]        ref_cnt_q;

    logic [2:0]         pipe_v_q;
    logic [15:0]        pipe_d_q [3];
    logic               dq_oe_q;
    logic [15:0]        dq_out_q;

    logic [15:0]        mem [DEPTH];

    logic cs, cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bst;
    logic e1, e2, e3, e4, e5, e6, err_any, rw_ok, act_ok, lmr_bad, pipe_busy, full_page;
    logic [8:0]         bl_mask;
    logic               issue_v, issue_rd;
    logic [1:0]         iss_bank;
    logic [12:0]        iss_row;
    logic [8:0]         iss_col;
    logic [MEM_AW-1:0]  issue_addr;

    // Sequential column within the aligned block selected by the burst-length mask.
    function automatic logic [8:0] col_inc(input logic [8:0] c, input logic [8:0] m);
        return (c & ~m) | ((c + 9'd1) & m);
    endfunction

    assign cs      = ~sdram_cmd[3];
    assign cmd_act = cs && sdram_cmd[2:0] == 3'b011;
    assign cmd_rd  = cs && sdram_cmd[2:0] == 3'b101;
    assign cmd_wr  = cs && sdram_cmd[2:0] == 3'b100;
    assign cmd_pre = cs && sdram_cmd[2:0] == 3'b010;
    assign cmd_ref = cs && sdram_cmd[2:0] == 3'b001;
    assign cmd_lmr = cs && sdram_cmd[2:0] == 3'b000;
    assign cmd_bst = cs && sdram_cmd[2:0] == 3'b110;

    always_comb begin
        bl_mask = 9'd0;
        case (bl_code_q)
            3'b001:  bl_mask = 9'd1;
            3'b010:  bl_mask = 9'd3;
            3'b011:  bl_mask = 9'd7;
            3'b111:  bl_mask = 9'd511;
            default: bl_mask = 9'd0;
        endcase
    end

    assign full_page = (bl_code_q == 3'b111);
    assign lmr_bad   = (sdram_addr[6:4] != 3'd2 && sdram_addr[6:4] != 3'd3)
                     || (sdram_addr[2] && !(sdram_addr[1] && sdram_addr[0]));
    // The output register is not counted: that beat has already left the pipeline.
    assign pipe_busy = pipe_v_q[0] | pipe_v_q[1] | (cl3_q & pipe_v_q[2]);

    assign e1 = (cmd_rd | cmd_wr) & ~bank_open_q[sdram_bank_addr];
    assign e2 = cmd_act & bank_open_q[sdram_bank_addr];
    assign e3 = (cmd_rd | cmd_wr | cmd_act) & ~mode_loaded_q;
    assign e4 = cmd_lmr & lmr_bad;
    assign e5 = cmd_wr & pipe_busy;
    assign e6 = cmd_ref & (|bank_open_q);
    assign err_any = e1 | e2 | e3 | e4 | e5 | e6;
    assign rw_ok   = (cmd_rd | cmd_wr) & ~e1 & ~e3 & ~e5;
    assign act_ok  = cmd_act & ~e2 & ~e3;

    always_comb begin
        err_code_d = err_code_q;
        if (e1)      err_code_d = 3'd1;
        else if (e2) err_code_d = 3'd2;
        else if (e3) err_code_d = 3'd3;
        else if (e4) err_code_d = 3'd4;
        else if (e5) err_code_d = 3'd5;
        else if (e6) err_code_d = 3'd6;
    end

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        issue_v  = 1'b0;
        issue_rd = 1'b0;
        iss_bank = bank_q;
        iss_row  = row_q;
        iss_col  = col_q;
        if (cmd_rd || cmd_wr) begin
            state_d = S_IDLE;
            if (rw_ok) begin
                issue_v  = 1'b1;
                issue_rd = cmd_rd;
                iss_bank = sdram_bank_addr;
                iss_row  = open_row_q[sdram_bank_addr];
                iss_col  = sdram_addr[8:0];
                bank_d   = sdram_bank_addr;
                row_d    = open_row_q[sdram_bank_addr];
                col_d    = col_inc(sdram_addr[8:0], bl_mask);
                cnt_d    = bl_mask;
                if (bl_mask != 9'd0)
                    state_d = cmd_rd ? S_RD_BURST : S_WR_BURST;
            end
        end else if (cmd_bst || (cmd_pre && (sdram_addr[10] || sdram_bank_addr == bank_q))) begin
            state_d = S_IDLE;
        end else if (state_q != S_IDLE) begin
            issue_v  = 1'b1;
            issue_rd = (state_q == S_RD_BURST);
            col_d    = col_inc(col_q, bl_mask);
            cnt_d    = cnt_q - 9'd1;
            if (!full_page && cnt_q == 9'd1)
                state_d = S_IDLE;
        end
    end

    assign issue_addr = MEM_AW'({iss_bank, iss_row, iss_col});

    always_ff @(posedge clk_100M) begin
        if (issue_v && !issue_rd)
            mem[issue_addr] <= sdram_dq_in;
    end

    always_ff @(posedge clk_100M or negedge locked_rst_n) begin
        if (!locked_rst_n) begin
            state_q       <= S_IDLE;
            bank_q        <= 2'd0;
            row_q         <= 13'd0;
            col_q         <= 9'd0;
            cnt_q         <= 9'd0;
            bank_open_q   <= 4'd0;
            for (int i = 0; i < 4; i++) open_row_q[i] <= 13'd0;
            cl3_q         <= 1'b1;
            bl_code_q     <= 3'b000;
            mode_loaded_q <= 1'b0;
            err_flag_q    <= 1'b0;
            err_code_q    <= 3'd0;
            ref_cnt_q     <= 16'd0;
            pipe_v_q      <= 3'd0;
            for (int i = 0; i < 3; i++) pipe_d_q[i] <= 16'd0;
            dq_oe_q       <= 1'b0;
            dq_out_q      <= 16'd0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            if (act_ok) begin
                bank_open_q[sdram_bank_addr] <= 1'b1;
                open_row_q[sdram_bank_addr]  <= sdram_addr;
            end
            if (cmd_pre) begin
                if (sdram_addr[10]) bank_open_q <= 4'd0;
                else                bank_open_q[sdram_bank_addr] <= 1'b0;
            end
            if (cmd_lmr && !lmr_bad) begin
                cl3_q         <= (sdram_addr[6:4] == 3'd3);
                bl_code_q     <= sdram_addr[2:0];
                mode_loaded_q <= 1'b1;
            end
            if (err_any) begin
                err_flag_q <= 1'b1;
                err_code_q <= err_code_d;
            end
            if (cmd_ref) ref_cnt_q <= ref_cnt_q + 16'd1;
            // Invalid stages carry zero so the output reads 0 whenever oe is low.
            pipe_v_q[0] <= issue_v & issue_rd;
            pipe_d_q[0] <= (issue_v && issue_rd) ? mem[issue_addr] : 16'd0;
            pipe_v_q[1] <= pipe_v_q[0];
            pipe_d_q[1] <= pipe_d_q[0];
            pipe_v_q[2] <= pipe_v_q[1];
            pipe_d_q[2] <= pipe_d_q[1];
            dq_oe_q     <= cl3_q ? pipe_v_q[2] : pipe_v_q[1];
            dq_out_q    <= cl3_q ? pipe_d_q[2] : pipe_d_q[1];
        end
    end

    assign sdram_dq_out = dq_out_q;
    assign sdram_dq_oe  = dq_oe_q;
    assign mode_loaded  = mode_loaded_q;
    assign err_flag     = err_flag_q;
    assign err_code     = err_code_q;
    assign ref_cnt      = ref_cnt_q;

endmodule

// File: tb/tb_sdram_resp.sv
// tb/tb_sdram_resp.sv - directed and randomized checks of sdram_resp against a burst-schedule reference model
module tb_sdram_resp;

    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000, C_BST = 4'b0110;

    logic        clk = 1'b0;
    logic        locked_rst_n;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank_addr;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_in;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        mode_loaded;
    logic        err_flag;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;

    always #5 clk = ~clk;

    sdram_resp #(.MEM_AW(10)) dut (
        .clk_100M        (clk),
        .locked_rst_n    (locked_rst_n),
        .sdram_cmd       (sdram_cmd),
        .sdram_bank_addr (sdram_bank_addr),
        .sdram_addr      (sdram_addr),
        .sdram_dq_in     (sdram_dq_in),
        .sdram_dq_out    (sdram_dq_out),
        .sdram_dq_oe     (sdram_dq_oe),
        .mode_loaded     (mode_loaded),
        .err_flag        (err_flag),
        .err_code        (err_code),
        .ref_cnt         (ref_cnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_n = 0;
    logic        exp_oe [0:4095];
    logic [15:0] exp_dq [0:4095];
    logic [15:0] mm     [0:1023];
    logic [15:0] wdata  [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, want);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 4096; i++) begin
            exp_oe[i] = 1'b0;
            exp_dq[i] = 16'd0;
        end
    endtask

    // One clock: drive a command, advance one edge, compare the read port with the schedule.
    task automatic step(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] a, input logic [15:0] dq);
        sdram_cmd       = cmd;
        sdram_bank_addr = ba;
        sdram_addr      = a;
        sdram_dq_in     = dq;
        @(posedge clk);
        edge_n++;
        #1;
        chk("dq_oe", 32'(sdram_dq_oe), 32'(exp_oe[edge_n]));
        chk("dq_out", 32'(sdram_dq_out), 32'(exp_dq[edge_n]));
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(C_NOP, 2'd0, 13'd0, 16'd0);
    endtask

    function automatic int colseq(input int col, input int i, input int bl);
        if (bl == 512) return (col + i) % 512;
        return (col - col % bl) + (col + i) % bl;
    endfunction

    function automatic int widx(input int ba, input int row, input int col);
        return ((ba * 8192 + row) * 512 + col) % 1024;
    endfunction

    task automatic wr_burst(input int ba, input int row, input int col, input int bl, input int n);
        for (int i = 0; i < n; i++) begin
            mm[widx(ba, row, colseq(col, i, bl))] = wdata[i];
            step(i == 0 ? C_WR : C_NOP, 2'(ba), i == 0 ? 13'(col) : 13'd0, wdata[i]);
        end
    endtask

    task automatic rd_burst(input int ba, input int row, input int col, input int bl, input int n, input int cl);
        int k;
        k = edge_n + 1;
        for (int i = 0; i < n; i++) begin
            exp_oe[k + cl + i] = 1'b1;
            exp_dq[k + cl + i] = mm[widx(ba, row, colseq(col, i, bl))];
        end
        for (int i = 0; i < n; i++)
            step(i == 0 ? C_RD : C_NOP, 2'(ba), i == 0 ? 13'(col) : 13'd0, 16'd0);
    endtask

    initial begin
        int cl, blc, bl, ba, row, col, rs;
        locked_rst_n    = 1'b0;
        sdram_cmd       = C_NOP;
        sdram_bank_addr = 2'd0;
        sdram_addr      = 13'd0;
        sdram_dq_in     = 16'd0;
        clear_exp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dq_out", 32'(sdram_dq_out), 32'd0);
        chk("rst_dq_oe", 32'(sdram_dq_oe), 32'd0);
        chk("rst_mode_loaded", 32'(mode_loaded), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_ref_cnt", 32'(ref_cnt), 32'd0);
        locked_rst_n = 1'b1;

        repeat (3) step(C_REF, 2'd0, 13'd0, 16'd0);
        chk("ref_cnt_3", 32'(ref_cnt), 32'd3);
        chk("ref_no_err", 32'(err_flag), 32'd0);

        // CL2 BL4 write then read at column 0
        step(C_LMR, 2'd0, 13'h022, 16'd0);
        chk("mode_loaded", 32'(mode_loaded), 32'd1);
        step(C_ACT, 2'd0, 13'd0, 16'd0);
        for (int i = 0; i < 4; i++) wdata[i] = 16'(i + 1);
        wr_burst(0, 0, 0, 4, 4);
        rd_burst(0, 0, 0, 4, 4, 2);
        nops(4);
        chk("cl2_no_err", 32'(err_flag), 32'd0);

        // BL8 write, then CL3 BL4 read from column 6 wraps inside the 4..7 block
        step(C_LMR, 2'd0, 13'h033, 16'd0);
        for (int i = 0; i < 8; i++) wdata[i] = 16'(i + 1);
        wr_burst(0, 0, 0, 8, 8);
        step(C_LMR, 2'd0, 13'h032, 16'd0);
        rd_burst(0, 0, 6, 4, 4, 3);
        nops(5);
        chk("wrap_model_7", 32'(mm[6]), 32'd7);

        // Full page across 511->0, stopped by BURST TERMINATE
        step(C_LMR, 2'd0, 13'h027, 16'd0);
        for (int i = 0; i < 10; i++) wdata[i] = 16'(i);
        wr_burst(0, 0, 505, 512, 10);
        step(C_BST, 2'd0, 13'd0, 16'd0);
        rd_burst(0, 0, 505, 512, 10, 2);
        step(C_BST, 2'd0, 13'd0, 16'd0);
        nops(4);

        // Randomized mode, bank, row and start columns
        for (int it = 0; it < 8; it++) begin
            cl  = int'($urandom_range(2, 3));
            blc = int'($urandom_range(0, 3));
            bl  = 1 << blc;
            ba  = int'($urandom_range(0, 3));
            row = int'($urandom_range(0, 8191));
            col = int'($urandom_range(0, 511));
            rs  = (col - col % bl) + int'($urandom_range(0, bl - 1));
            for (int i = 0; i < bl; i++) wdata[i] = 16'($urandom);
            step(C_PRE, 2'd0, 13'h400, 16'd0);
            step(C_LMR, 2'd0, 13'((cl << 4) | blc), 16'd0);
            step(C_ACT, 2'(ba), 13'(row), 16'd0);
            wr_burst(ba, row, col, bl, bl);
            rd_burst(ba, row, rs, bl, bl, cl);
            nops(cl + 2);
        end
        chk("random_no_err", 32'(err_flag), 32'd0);

        // WRITE while a read beat is in flight: code 5, and the write is dropped
        step(C_LMR, 2'd0, 13'h022, 16'd0);
        step(C_PRE, 2'd0, 13'h400, 16'd0);
        step(C_ACT, 2'd0, 13'd0, 16'd0);
        rd_burst(0, 0, 0, 4, 1, 2);
        step(C_WR, 2'd0, 13'd0, 16'hDEAD);
        chk("err5_flag", 32'(err_flag), 32'd1);
        chk("err5_code", 32'(err_code), 32'd5);
        nops(4);
        rd_burst(0, 0, 0, 4, 4, 2);
        nops(4);

        // Closed-bank read, double ACTIVE, refresh with a bank open
        step(C_PRE, 2'd0, 13'h400, 16'd0);
        step(C_RD, 2'd2, 13'd0, 16'd0);
        chk("err1_code", 32'(err_code), 32'd1);
        nops(4);
        step(C_ACT, 2'd0, 13'd0, 16'd0);
        step(C_ACT, 2'd0, 13'd0, 16'd0);
        chk("err2_code", 32'(err_code), 32'd2);
        step(C_REF, 2'd0, 13'd0, 16'd0);
        chk("err6_code", 32'(err_code), 32'd6);
        chk("ref_cnt_4", 32'(ref_cnt), 32'd4);

        // Fresh reset: mode-related errors
        locked_rst_n = 1'b0;
        @(posedge clk);
        #1;
        locked_rst_n = 1'b1;
        clear_exp();
        chk("rst2_err_flag", 32'(err_flag), 32'd0);
        chk("rst2_ref_cnt", 32'(ref_cnt), 32'd0);
        step(C_ACT, 2'd1, 13'd5, 16'd0);
        chk("err3_code", 32'(err_code), 32'd3);
        step(C_LMR, 2'd0, 13'h012, 16'd0);
        chk("err4_cl1_code", 32'(err_code), 32'd4);
        chk("err4_cl1_mode", 32'(mode_loaded), 32'd0);
        step(C_LMR, 2'd0, 13'h022, 16'd0);
        chk("lmr_ok_mode", 32'(mode_loaded), 32'd1);
        step(C_LMR, 2'd0, 13'h024, 16'd0);
        chk("err4_bl_code", 32'(err_code), 32'd4);
        step(C_ACT, 2'd1, 13'd5, 16'd0);
        chk("act_ok_keeps_code", 32'(err_code), 32'd4);
        for (int i = 0; i < 4; i++) wdata[i] = 16'($urandom);
        wr_burst(1, 5, 8, 4, 4);
        rd_burst(1, 5, 9, 4, 4, 2);

        // Reset mid-burst: outputs clear without waiting for a clock edge
        #2;
        locked_rst_n = 1'b0;
        #1;
        chk("midrst_dq_oe", 32'(sdram_dq_oe), 32'd0);
        chk("midrst_dq_out", 32'(sdram_dq_out), 32'd0);
        chk("midrst_mode", 32'(mode_loaded), 32'd0);
        chk("midrst_err_flag", 32'(err_flag), 32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_ref_cnt", 32'(ref_cnt), 32'd0);
        clear_exp();
        @(posedge clk);
        #1;
        locked_rst_n = 1'b1;
        nops(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_resp.md
# sdram_resp

Synthesizable SDRAM device responder: decodes the 4-bit command bus, bank and address lines driven by the controller-side modules (sdram_init, sdram_write, sdram_read and their arbiter) and behaves as a small SDRAM, capturing write bursts and returning read bursts after the programmed CAS latency. It sits at the device end of the SDRAM interface in place of the external memory, for fast RTL regression and FPGA loopback. It also flags protocol violations so benches can check controller command sequencing.

## Interface
- MEM_AW, 10: storage address width; word index = low MEM_AW bits of {bank[1:0], row[12:0], col[8:0]}.
- clk_100M  in  1  clock; all inputs sampled and outputs registered on the rising edge.
- locked_rst_n  in  1  reset, asynchronous, active-low.
- sdram_cmd  in  4  {CS_n, RAS_n, CAS_n, WE_n}.
- sdram_bank_addr  in  2  bank select.
- sdram_addr  in  13  row (ACTIVE), column [8:0] (READ/WRITE), A10 all-banks (PRECHARGE), mode (LOAD MODE).
- sdram_dq_in  in  16  write data from controller.
- sdram_dq_out  out  16  read data.
- sdram_dq_oe  out  1  high while sdram_dq_out carries a read beat.
- mode_loaded  out  1  set by first LOAD MODE, sticky.
- err_flag  out  1  sticky protocol-error flag.
- err_code  out  3  code of most recent error.
- ref_cnt  out  16  AUTO REFRESH count, wraps at 0xFFFF to 0.

## Operation
- Commands: CS_n=1 deselect; 0111 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE; 0110 BURST TERMINATE.
- Per bank: open flag + 13-bit open row. ACTIVE opens bank with row; PRECHARGE closes addressed bank, or all banks if A10=1.
- LOAD MODE: A[2:0] burst length 000=1, 001=2, 010=4, 011=8, 111=full page (512); A[6:4] CAS latency 2 or 3. Reset mode: CL=3, BL=1.
- Burst engine states: IDLE, WR_BURST, RD_BURST. READ/WRITE loads bank, open row, start column, beat counter = BL, enters RD_BURST/WR_BURST; returns to IDLE after BL beats (full page: never, until terminated).
- Column sequence: sequential, wrapping within aligned BL block (BL=4, start 6 -> 6,7,4,5); full page wraps 511->0.
- Write beats: one word stored per cycle from sdram_dq_in, first beat on the WRITE edge.
- Read beats: one column issued per cycle from the READ edge; each issued beat delayed through a CL-deep valid/data pipeline.
- Termination: new READ/WRITE, BURST TERMINATE, or PRECHARGE of the burst bank (or all) stops issue at that edge; new command's beat replaces it. Read beats already issued still emerge.
- Errors (set err_flag, load err_code): 1 READ/WRITE to closed bank; 2 ACTIVE to open bank; 3 READ/WRITE/ACTIVE before mode_loaded; 4 LOAD MODE with CL not 2/3 or BL field 100-110 (mode unchanged); 5 WRITE issued while a read beat is in the pipeline. Multiple in one cycle: smallest code. Erroneous READ/WRITE performs no access.
- AUTO REFRESH: ref_cnt+1; with any bank open, also code 6.

## Timing
- Reset values: sdram_dq_out=0, sdram_dq_oe=0, mode_loaded=0, err_flag=0, err_code=0, ref_cnt=0; all banks closed; engine IDLE; pipeline empty. Storage contents not reset.
- READ sampled at edge k: beat i valid on sdram_dq_out with sdram_dq_oe=1 after edge k+CL+i, held one cycle.
- sdram_dq_oe low otherwise; sdram_dq_out returns to 0 when oe low.
- WRITE at edge k: beat i captured at edge k+i; read of same word issued at edge k+i+1 or later returns new data.
- Reset mid-burst: burst aborted, pipeline flushed, oe low immediately (asynchronous).
- mode_loaded, err flags, ref_cnt update at the edge sampling the command.

## Test plan
- Reset, LOAD MODE 0x022 (CL2, BL4), ACTIVE bank0 row0, WRITE col0 data 1..4, READ col0 -> dq_oe high for 4 cycles from edge READ+2, data 1,2,3,4, err_flag 0.
- Same with mode 0x032 (CL3) and READ col 6 after writing 1..8 at col0 BL8 -> data 7,8,5,6 from edge READ+3.
- Full page (0x027), write 0..9 at col 505, BURST TERMINATE after 10 beats -> read col 505 returns 0..9 across wrap 511->0; oe drops CL cycles after BST edge.
- READ to closed bank 2 -> err_flag=1, err_code=1, no oe; then ACTIVE bank0 twice -> err_code=2.
- ACTIVE before LOAD MODE -> err_code=3; LOAD MODE CL=1 -> err_code=4, mode unchanged.
- Three AUTO REFRESH with all banks closed -> ref_cnt=3, err_flag 0; assert reset during read burst -> all outputs 0 immediately.
